inv_square_unit: RTL and testbench

Iterative float32 unit computing x = 1/(y·y): the inverse mapping of the fast inverse square root datapath. Its input is a y ≈ 1/sqrt(x), and it recovers x. It sits downstream of the inverse-square-root pipeline, where it closes an on-board loopback self-check on the ZedBoard. It also serves as a standalone reciprocal-square operator behind a valid/ready handshake. Arithmetic is bit-exact: one 24×24 square, then a 24-step restoring division, with truncation rounding and flush-to-zero.

---
 rtl/inv_square_unit.sv | 164 ++++++++++++++++
 tb/tb_inv_square_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/inv_square_unit.sv
// Iterative float32 x = 1/(y*y): one 24x24 square, 24-step restoring divide, truncation, FTZ.
// Optional out_flags {nan, overflow, divzero} when INV_SQUARE_FLAGS_EN is defined.
module inv_square_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef INV_SQUARE_FLAGS_EN
  ,
  output logic [2:0]  out_flags
`endif
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [23:0] ONE  = 24'h80_0000;

  typedef enum logic [2:0] {IDLE, SQUARE, DIVIDE, PACK, DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        y_q, y_d;
  logic [23:0]        s_q, s_d;
  logic signed [9:0]  e2_q, e2_d;
  logic [23:0]        r_q, r_d;
  logic [23:0]        quo_q, quo_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  // Classification and result fields, used only in PACK
  logic [24:0]        p_hi;
  logic signed [8:0]  e_s;
  logic [24:0]        r_sh;
  logic signed [10:0] be;
  logic               is_dz, is_nan, is_inf, is_ovf, is_unf;

`ifdef INV_SQUARE_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  assign out_flags = flags_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    p_hi   = 25'((48'(y_q[30:23] != 8'd0 ? {1'b1, y_q[22:0]} : {1'b1, y_q[22:0]}) *
                  48'({1'b1, y_q[22:0]})) >> 23);
    e_s    = $signed({1'b0, y_q[30:23]}) - 9'sd127;
    r_sh   = {r_q, 1'b0};
    be     = (s_q == ONE ? 11'sd127 : 11'sd126) - $signed({e2_q[9], e2_q});
    is_dz  = (y_q[30:23] == 8'd0);
    is_nan = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
    is_inf = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
    is_ovf = !is_dz && (y_q[30:23] != 8'hFF) && (be >= 11'sd255);
    is_unf = !is_dz && (y_q[30:23] != 8'hFF) && (be <= 11'sd0);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    s_d         = s_q;
    e2_d        = e2_q;
    r_d         = r_q;
    quo_d       = quo_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef INV_SQUARE_FLAGS_EN
    flags_d     = flags_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d     = in_data;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        // P in Q2.46; keep the 24 bits under the leading one as s in [1,2)
        s_d     = p_hi[24] ? p_hi[24:1] : p_hi[23:0];
        e2_d    = $signed({e_s, p_hi[24]});
        r_d     = ONE;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = DIVIDE;
      end
      DIVIDE: begin
        if (r_sh >= {1'b0, s_q}) begin
          r_d   = 24'(r_sh - {1'b0, s_q});
          quo_d = {quo_q[22:0], 1'b1};
        end else begin
          r_d   = r_sh[23:0];
          quo_d = {quo_q[22:0], 1'b0};
        end
        if (cnt_q == 5'd23) begin
          cnt_d   = '0;
          state_d = PACK;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      PACK: begin
        if (is_dz || is_ovf)      out_data_d = PINF;
        else if (is_nan)          out_data_d = QNAN;
        else if (is_inf || is_unf) out_data_d = 32'd0;
        else if (s_q == ONE)      out_data_d = {1'b0, be[7:0], 23'd0};
        else                      out_data_d = {1'b0, be[7:0], quo_q[22:0]};
`ifdef INV_SQUARE_FLAGS_EN
        flags_d = {is_nan, is_ovf, is_dz};
`endif
        state_d = DONE;
      end
      DONE: begin
        // out_valid is registered one cycle after entering DONE
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef INV_SQUARE_FLAGS_EN
          flags_d     = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      y_q         <= '0;
      s_q         <= '0;
      e2_q        <= '0;
      r_q         <= '0;
      quo_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef INV_SQUARE_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      s_q         <= s_d;
      e2_q        <= e2_d;
      r_q         <= r_d;
      quo_q       <= quo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef INV_SQUARE_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_inv_square_unit.sv
// Directed bench for inv_square_unit: hand-computed 1/(y*y) vectors, latency, backpressure, abort.
module tb_inv_square_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef INV_SQUARE_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  int errors = 0;
  int checks = 0;

  inv_square_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef INV_SQUARE_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] expf);
`ifdef INV_SQUARE_FLAGS_EN
    chk(tag, {29'd0, out_flags}, {29'd0, expf});
`else
    if (expf === 3'bxxx) $display("unreachable %s", tag);
`endif
  endtask

  // Accept y, wait for the result and check it with its latency.
  task automatic issue(input string tag, input logic [31:0] y, input logic [31:0] expv,
                       input logic [2:0] expf);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 100) begin step(); w++; end
    chk({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = y;
    step();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    lat = 0;
    while (!out_valid && lat < 40) begin step(); lat++; end
    chk({tag, ".lat"}, lat, 27);
    chk({tag, ".data"}, out_data, expv);
    chk_flags({tag, ".flags"}, expf);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".vld_lo"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_data", out_data, 32'd0);
    chk_flags("rst.flags", 3'b000);
    rst = 1'b0;
    step();

    issue("half", 32'h3F00_0000, 32'h4080_0000, 3'b000); take("half");
    issue("two", 32'h4000_0000, 32'h3E80_0000, 3'b000); take("two");
    issue("neg3", 32'hC040_0000, 32'h3DE3_8E38, 3'b000); take("neg3");
    issue("zero", 32'h0000_0000, 32'h7F80_0000, 3'b001); take("zero");
    issue("nan", 32'h7FC0_0001, 32'h7FC0_0000, 3'b100); take("nan");
    issue("inf", 32'h7F80_0000, 32'h0000_0000, 3'b000); take("inf");
    issue("ovf", 32'h1C80_0000, 32'h7F80_0000, 3'b010); take("ovf");
    issue("unf", 32'h5F80_0000, 32'h0000_0000, 3'b000); take("unf");

    // Backpressure: hold the result while pulsing other operands
    issue("bp", 32'h4000_0000, 32'h3E80_0000, 3'b000);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 32'h3F00_0000;
      step();
      chk("bp.hold_data", out_data, 32'h3E80_0000);
      chk("bp.hold_busy", {31'd0, in_ready}, 32'd0);
      chk("bp.hold_vld", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    take("bp");
    issue("bp_next", 32'hC040_0000, 32'h3DE3_8E38, 3'b000); take("bp_next");

    // Abort during DIVIDE
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.vld", {31'd0, out_valid}, 32'd0);
    chk("abort.idle", {31'd0, in_ready}, 32'd1);
    chk_flags("abort.flags", 3'b000);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort.no_out", seen, 0);
    issue("post", 32'h3F00_0000, 32'h4080_0000, 3'b000); take("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
